id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage core.
- Consumes the EX/MEM/WB control bundle from the ID-stage control bubble mux, plus ID operand and index fields, and presents them registered to the EX stage.
- Converts bubbles into clean all-zero control, so X never reaches EX.
- Produces the load-use hazard flag from its own registered state for the hazard unit.

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields.
- REG_AW, 5, register index width.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- freeze_i  in  1  global hold (memory stall); register keeps its contents.
- bubble_i  in  1  insert bubble (load-use stall or branch flush).
- EX_signal_i  in  2  EX control from ID mux.
- MEM_signal_i  in  3  [0]=MemRead, [1]=MemWrite, [2]=Branch.
- WB_signal_i  in  2  [0]=RegWrite, [1]=MemtoReg.
- pc_i  in  DATA_W  PC of ID instruction.
- rs1_data_i, rs2_data_i  in  DATA_W  register file read data.
- imm_i  in  DATA_W  sign-extended immediate.
- funct_i  in  10  funct7,funct3.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_AW  register indices.
- EX_signal_o, MEM_signal_o, WB_signal_o  out  2/3/2  registered control.
- pc_o, rs1_data_o, rs2_data_o, imm_o  out  DATA_W  registered data.
- funct_o  out  10  registered funct.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_AW  registered indices, forwarding unit.
- valid_o  out  1  EX slot holds a real instruction.
- load_use_o  out  1  load-use hazard vs instruction currently in ID.
- bubble_cnt_o  out  32  bubbles inserted (optional feature).
- freeze_cnt_o  out  32  freeze cycles (optional feature).

Behaviour:
- Reset (rst_i=0, asynchronous, any time including mid-freeze):
  - all control outputs 0; all data and index outputs 0; valid_o=0; counters 0.
  - Outputs are 0 while rst_i is low.
  - First capture is on the first rising edge after rst_i goes high.
- Per rising edge, in priority order:
  1. freeze_i=1: every register holds. bubble_i is ignored that cycle; upstream keeps bubble_i asserted until the freeze drops.
  2. bubble_i=1: control registers load 0, valid_o<=0. Data and index registers load their inputs (don't-care but defined, no X). Any X on the control inputs is never sampled into the register.
  3. Otherwise: all fields load their inputs, valid_o<=1.
- Latency: exactly 1 cycle from ID inputs to outputs. No combinational path from inputs to registered outputs.
- load_use_o (combinational from registered state plus rs1/rs2 inputs): 1 when all of the following hold:
  - valid_o=1
  - MEM_signal_o[0]=1
  - rd_addr_o != 0
  - rd_addr_o == rs1_addr_i, or rd_addr_o == rs2_addr_i
- load_use_o is 0 during reset. A bubble in EX never raises load_use_o.
- Back-to-back bubbles are allowed; each produces one zero-control slot.
- Freeze followed immediately by bubble: the bubble is taken on the first unfrozen edge.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt_o increments on each edge where freeze_i=0 and bubble_i=1.
  - freeze_cnt_o increments on each edge where freeze_i=1.
  - Both are 32-bit and saturate at 32'hFFFFFFFF; no wrap.
  - Both clear only on reset.
- Not defined: both ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- Reset mid-operation:
  - stimulus: rst_i low for 2 cycles while inputs are non-zero, then release.
  - response: all outputs 0 and valid_o=0 during reset; first capture on the first edge after release.
- Normal capture:
  - stimulus: WB=2'b01, MEM=3'b000, EX=2'b10, rs1_data=32'h1234, rd=5'd7.
  - response: the same values appear after 1 edge with valid_o=1.
- Bubble with X on control:
  - stimulus: bubble_i=1 with EX/MEM/WB inputs driven X.
  - response: control outputs exactly 0, valid_o=0, no X on any output.
- Freeze hold and priority:
  - stimulus: capture pc=32'h40, then freeze_i=1 for 3 cycles with pc_i=32'h44 and bubble_i=1.
  - response: pc_o stays 32'h40, valid_o stays 1; bubble is applied on the first unfrozen edge.
- Load-use detection:
  - stimulus: EX holds a load (MEM[0]=1) with rd=5'd5; ID presents rs2=5'd5.
  - response: load_use_o=1.
  - Same stimulus with rd=5'd0 -> load_use_o=0.
  - Same stimulus with a bubble in EX -> load_use_o=0.
- Counters (with ID_EX_PERF_CNT_EN):
  - stimulus: 4 bubbles and 3 freeze cycles, one of them with bubble_i=1.
  - response: bubble_cnt_o=4, freeze_cnt_o=3.
  - Preload a counter to 32'hFFFFFFFF, then drive one more event -> the counter stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register of the 5-stage core.
//               Registers the EX/MEM/WB control bundle together with the ID
//               operands and register indices, and presents them to EX one
//               cycle later. A bubble loads all-zero control, so no X on the
//               control inputs is ever captured. The load-use flag is built
//               from the registered EX-slot state and the rs1/rs2 indices of
//               the instruction currently in ID.
//
//               Optional bubble/freeze performance counters are enabled with
//               the macro ID_EX_PERF_CNT_EN. When the macro is undefined the
//               counter ports stay on the interface and are tied to 0.
//
// Ports       : clk_i, rst_i (async, active-low)
//               freeze_i  - hold every register
//               bubble_i  - load zero control, clear valid
//               EX/MEM/WB_signal_i, pc_i, rs1/rs2_data_i, imm_i, funct_i,
//               rs1/rs2/rd_addr_i                     - ID-stage fields
//               EX/MEM/WB_signal_o, pc_o, rs1/rs2_data_o, imm_o, funct_o,
//               rs1/rs2/rd_addr_o                     - registered fields
//               valid_o, load_use_o, bubble_cnt_o, freeze_cnt_o
//
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              freeze_i,
    input  logic              bubble_i,
    input  logic [1:0]        EX_signal_i,
    input  logic [2:0]        MEM_signal_i,
    input  logic [1:0]        WB_signal_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic [1:0]        EX_signal_o,
    output logic [2:0]        MEM_signal_o,
    output logic [1:0]        WB_signal_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              valid_o,
    output logic              load_use_o,
    output logic [31:0]       bubble_cnt_o,
    output logic [31:0]       freeze_cnt_o
);

    localparam logic [REG_AW-1:0] c_reg_zero = '0;

    // ------------------------------------------------------------------
    // Control registers and valid flag
    // ------------------------------------------------------------------
    logic [1:0] r_ex_signal;
    logic [2:0] r_mem_signal;
    logic [1:0] r_wb_signal;
    logic       r_valid;

    // The bubble branch never references the control inputs, so an X on
    // them during a bubble cannot propagate into EX.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_signal  <= '0;
            r_mem_signal <= '0;
            r_wb_signal  <= '0;
            r_valid      <= 1'b0;
        end else if (!freeze_i) begin
            if (bubble_i) begin
                r_ex_signal  <= '0;
                r_mem_signal <= '0;
                r_wb_signal  <= '0;
                r_valid      <= 1'b0;
            end else begin
                r_ex_signal  <= EX_signal_i;
                r_mem_signal <= MEM_signal_i;
                r_wb_signal  <= WB_signal_i;
                r_valid      <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data and index registers: loaded on every unfrozen edge, bubble or
    // not, so they always carry defined values.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [DATA_W-1:0] r_imm;
    logic [9:0]        r_funct;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] r_rd_addr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_funct    <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
        end else if (!freeze_i) begin
            r_pc       <= pc_i;
            r_rs1_data <= rs1_data_i;
            r_rs2_data <= rs2_data_i;
            r_imm      <= imm_i;
            r_funct    <= funct_i;
            r_rs1_addr <= rs1_addr_i;
            r_rs2_addr <= rs2_addr_i;
            r_rd_addr  <= rd_addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard: a real load in EX whose non-zero destination is a
    // source of the instruction in ID. r_valid gates out bubbles, and since
    // it is 0 in reset the flag is also 0 there.
    // ------------------------------------------------------------------
    logic w_rd_match;

    assign w_rd_match = (r_rd_addr == rs1_addr_i) || (r_rd_addr == rs2_addr_i);
    assign load_use_o = r_valid && r_mem_signal[0] && (r_rd_addr != c_reg_zero) && w_rd_match;

    // ------------------------------------------------------------------
    // Optional performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    logic [31:0] r_bubble_cnt;
    logic [31:0] r_freeze_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
            r_freeze_cnt <= '0;
        end else if (freeze_i) begin
            if (r_freeze_cnt != c_cnt_max) begin
                r_freeze_cnt <= r_freeze_cnt + 32'd1;
            end
        end else if (bubble_i) begin
            if (r_bubble_cnt != c_cnt_max) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign freeze_cnt_o = r_freeze_cnt;
`else
    assign bubble_cnt_o = '0;
    assign freeze_cnt_o = '0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign EX_signal_o  = r_ex_signal;
    assign MEM_signal_o = r_mem_signal;
    assign WB_signal_o  = r_wb_signal;
    assign valid_o      = r_valid;
    assign pc_o         = r_pc;
    assign rs1_data_o   = r_rs1_data;
    assign rs2_data_o   = r_rs2_data;
    assign imm_o        = r_imm;
    assign funct_o      = r_funct;
    assign rs1_addr_o   = r_rs1_addr;
    assign rs2_addr_o   = r_rs2_addr;
    assign rd_addr_o    = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Directed self-checking bench for id_ex_pipe_reg. Covers
//               reset, capture, bubble with X control, freeze priority,
//               load-use detection, mid-operation reset and the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        freeze_i, bubble_i;
    logic [1:0]  EX_signal_i, WB_signal_i;
    logic [2:0]  MEM_signal_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [1:0]  EX_signal_o, WB_signal_o;
    logic [2:0]  MEM_signal_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [9:0]  funct_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        valid_o, load_use_o;
    logic [31:0] bubble_cnt_o, freeze_cnt_o;

    int checks = 0;
    int errors = 0;

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .bubble_i(bubble_i),
        .EX_signal_i(EX_signal_i), .MEM_signal_i(MEM_signal_i), .WB_signal_i(WB_signal_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i),
        .EX_signal_o(EX_signal_o), .MEM_signal_o(MEM_signal_o), .WB_signal_o(WB_signal_o),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .funct_o(funct_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .valid_o(valid_o), .load_use_o(load_use_o),
        .bubble_cnt_o(bubble_cnt_o), .freeze_cnt_o(freeze_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every output concatenated, used for X screening.
    function automatic logic [255:0] all_outs();
        return {EX_signal_o, MEM_signal_o, WB_signal_o, pc_o, rs1_data_o, rs2_data_o,
                imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o, valid_o, load_use_o,
                bubble_cnt_o, freeze_cnt_o};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {25'd0, EX_signal_o, MEM_signal_o, WB_signal_o}, 32'd0);
        check({tag, "_pc"}, pc_o, 32'd0);
        check({tag, "_data"}, rs1_data_o | rs2_data_o | imm_o, 32'd0);
        check({tag, "_idx"}, {7'd0, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_load_use"}, {31'd0, load_use_o}, 32'd0);
        check({tag, "_cnt"}, bubble_cnt_o | freeze_cnt_o, 32'd0);
    endtask

    task automatic set_inputs(input logic [1:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                              input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd);
        EX_signal_i = ex; MEM_signal_i = mem; WB_signal_i = wb; pc_i = pc;
        rs1_addr_i = rs1; rs2_addr_i = rs2; rd_addr_i = rd;
    endtask

    initial begin
        // ---------------- Reset with non-zero inputs ----------------
        rst_i = 1'b0; freeze_i = 1'b0; bubble_i = 1'b0;
        set_inputs(2'b11, 3'b111, 2'b11, 32'hDEAD_BEEF, 5'd3, 5'd4, 5'd3);
        rs1_data_i = 32'hAAAA_5555; rs2_data_i = 32'h5555_AAAA; imm_i = 32'hFFFF_FFF0;
        funct_i = 10'h3FF;
        tick();
        check_all_zero("rst_c1");
        tick();
        check_all_zero("rst_c2");
        rst_i = 1'b1;
        #1;
        check("rst_release_no_capture", pc_o, 32'd0);

        // ---------------- Normal capture ----------------
        set_inputs(2'b10, 3'b000, 2'b01, 32'h0000_0100, 5'd1, 5'd2, 5'd7);
        rs1_data_i = 32'h0000_1234; rs2_data_i = 32'h0000_5678; imm_i = 32'hFFFF_FFFC;
        funct_i = 10'h205;
        tick();
        check("cap_ex", {30'd0, EX_signal_o}, 32'd2);
        check("cap_mem", {29'd0, MEM_signal_o}, 32'd0);
        check("cap_wb", {30'd0, WB_signal_o}, 32'd1);
        check("cap_pc", pc_o, 32'h0000_0100);
        check("cap_rs1_data", rs1_data_o, 32'h0000_1234);
        check("cap_rs2_data", rs2_data_o, 32'h0000_5678);
        check("cap_imm", imm_o, 32'hFFFF_FFFC);
        check("cap_funct", {22'd0, funct_o}, 32'h205);
        check("cap_idx", {17'd0, rs1_addr_o, rs2_addr_o, rd_addr_o}, {17'd0, 5'd1, 5'd2, 5'd7});
        check("cap_valid", {31'd0, valid_o}, 32'd1);
        // Changing inputs mid-cycle must not reach the outputs.
        pc_i = 32'h0000_0104;
        #2;
        check("no_comb_path", pc_o, 32'h0000_0100);

        // ---------------- Bubble with X control ----------------
        bubble_i = 1'b1;
        EX_signal_i = 'x; MEM_signal_i = 'x; WB_signal_i = 'x;
        pc_i = 32'h0000_0200;
        tick();
        check("bub_ctrl", {25'd0, EX_signal_o, MEM_signal_o, WB_signal_o}, 32'd0);
        check("bub_valid", {31'd0, valid_o}, 32'd0);
        check("bub_no_x", {31'd0, $isunknown(all_outs())}, 32'd0);
        check("bub_pc_loaded", pc_o, 32'h0000_0200);

        // ---------------- Freeze hold and priority ----------------
        bubble_i = 1'b0;
        set_inputs(2'b01, 3'b000, 2'b01, 32'h0000_0040, 5'd1, 5'd2, 5'd8);
        tick();
        check("frz_cap_pc", pc_o, 32'h0000_0040);
        freeze_i = 1'b1; bubble_i = 1'b1; pc_i = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz_hold_pc_%0d", i), pc_o, 32'h0000_0040);
            check($sformatf("frz_hold_valid_%0d", i), {31'd0, valid_o}, 32'd1);
            check($sformatf("frz_hold_ex_%0d", i), {30'd0, EX_signal_o}, 32'd1);
        end
        freeze_i = 1'b0;
        tick();
        check("frz_then_bub_valid", {31'd0, valid_o}, 32'd0);
        check("frz_then_bub_ctrl", {25'd0, EX_signal_o, MEM_signal_o, WB_signal_o}, 32'd0);
        check("frz_then_bub_pc", pc_o, 32'h0000_0044);

        // Two more back-to-back bubbles: 4 bubbles total, 3 freeze cycles.
        tick();
        check("b2b_bub1_valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("b2b_bub2_valid", {31'd0, valid_o}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        check("cnt_bubble", bubble_cnt_o, 32'd4);
        check("cnt_freeze", freeze_cnt_o, 32'd3);
`else
        check("cnt_bubble_tied", bubble_cnt_o, 32'd0);
        check("cnt_freeze_tied", freeze_cnt_o, 32'd0);
`endif

        // ---------------- Load-use detection ----------------
        bubble_i = 1'b0;
        set_inputs(2'b01, 3'b001, 2'b11, 32'h0000_0300, 5'd3, 5'd9, 5'd5);
        tick();
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd5;
        #1;
        check("lu_rs2_match", {31'd0, load_use_o}, 32'd1);
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd9;
        #1;
        check("lu_rs1_match", {31'd0, load_use_o}, 32'd1);
        rs1_addr_i = 5'd4; rs2_addr_i = 5'd6;
        #1;
        check("lu_no_match", {31'd0, load_use_o}, 32'd0);
        // Load targeting x0.
        set_inputs(2'b01, 3'b001, 2'b11, 32'h0000_0304, 5'd0, 5'd0, 5'd0);
        tick();
        check("lu_rd_zero", {31'd0, load_use_o}, 32'd0);
        // Store (MemRead=0) with matching rd.
        set_inputs(2'b01, 3'b010, 2'b00, 32'h0000_0308, 5'd1, 5'd5, 5'd5);
        tick();
        check("lu_not_load", {31'd0, load_use_o}, 32'd0);
        // Bubble in EX with load-like inputs and matching rd.
        bubble_i = 1'b1;
        set_inputs(2'b01, 3'b001, 2'b11, 32'h0000_030C, 5'd1, 5'd5, 5'd5);
        tick();
        check("lu_bubble_rd", {27'd0, rd_addr_o}, 32'd5);
        check("lu_bubble", {31'd0, load_use_o}, 32'd0);

        // ---------------- Reset mid-operation, during freeze ----------------
        bubble_i = 1'b0;
        set_inputs(2'b10, 3'b001, 2'b01, 32'h0000_0400, 5'd6, 5'd2, 5'd6);
        tick();
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        check("pre_rst_load_use", {31'd0, load_use_o}, 32'd1);
        freeze_i = 1'b1;
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("rst_async");
        tick();
        tick();
        check_all_zero("rst_hold");
        rst_i = 1'b1;
        freeze_i = 1'b0;
        set_inputs(2'b11, 3'b100, 2'b10, 32'h0000_0500, 5'd1, 5'd2, 5'd9);
        #1;
        check("rst_rel_pc0", pc_o, 32'd0);
        tick();
        check("rst_first_cap_pc", pc_o, 32'h0000_0500);
        check("rst_first_cap_valid", {31'd0, valid_o}, 32'd1);
        check("rst_first_cap_mem", {29'd0, MEM_signal_o}, 32'd4);

`ifdef ID_EX_PERF_CNT_EN
        // ---------------- Counter saturation ----------------
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        force dut.r_freeze_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_bubble_cnt;
        release dut.r_freeze_cnt;
        bubble_i = 1'b1;
        tick();
        check("sat_bubble", bubble_cnt_o, 32'hFFFF_FFFF);
        freeze_i = 1'b1;
        tick();
        check("sat_freeze", freeze_cnt_o, 32'hFFFF_FFFF);
        freeze_i = 1'b0;
        bubble_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
